bus_arbiter: RTL and testbench
==============================

// Module: bus_arbiter
// PURPOSE
//  Shares one bus_if slave (memory or peripheral) between NUM_M bus_if masters, e.g. fetch (read-only) and load/store.
//  Read and write channels are arbitrated independently, each with its own round-robin pointer.
//  Losers receive a stall; read data returns after READ_LAT cycles with a one-hot valid routed to the issuing master.
//  Sits between the core's master ports and the single slave port of the memory map.
// PARAMETERS
//  NUM_M     2  number of masters, 2..8; index 0 wins all ties out of reset
//  READ_LAT  1  slave read latency in cycles (s_rdata valid READ_LAT cycles after s_ren), 1..4
// PORTS
//  clk         in   1         clock, all state on rising edge
//  rst_n       in   1         asynchronous active-low reset
//  m_ren       in   NUM_M     per-master read request
//  m_raddr     in   NUM_M*32  per-master read address, master i at [32*i+:32]
//  m_rstall    out  NUM_M     read request not accepted this cycle
//  m_rdata     out  32        read data, shared by all masters
//  m_rvalid    out  NUM_M     one-hot: m_rdata belongs to master i this cycle
//  m_wen       in   NUM_M     per-master write request
//  m_waddr     in   NUM_M*32  per-master write address
//  m_wdata     in   NUM_M*32  per-master write data
//  m_bytemask  in   NUM_M*4   per-master byte enables
//  m_wstall    out  NUM_M     write request not accepted this cycle
//  s_ren       out  1         slave read enable
//  s_raddr     out  32        slave read address
//  s_rdata     in   32        slave read data
//  s_wen       out  1         slave write enable
//  s_waddr     out  32        slave write address
//  s_wdata     out  32        slave write data
//  s_bytemask  out  4         slave byte enables
// BEHAVIOUR
//  - Reset: rd_ptr = wr_ptr = 0; read-tag pipeline cleared; m_rvalid = 0.
//    Combinational outputs follow from the reset state: with no requests, s_ren = s_wen = 0 and m_rstall = m_wstall = 0.
//    Reset asserted mid-operation drops in-flight reads; no m_rvalid is produced for them.
//  - Arbitration, per channel, combinational in the same cycle:
//    grant = first requester at or after ptr, scanning i = ptr, ptr+1, ..., NUM_M-1, 0, ... (mod NUM_M).
//    On an accepted request, ptr <= (grant+1) mod NUM_M; with no request, ptr holds.
//  - Accepted read: s_ren = 1 and s_raddr = m_raddr[grant]; every other requesting master gets m_rstall = 1.
//    Accepted write: s_wen = 1 and s_waddr/s_wdata/s_bytemask come from the granted master; other requesters get m_wstall = 1.
//    m_rstall[i] / m_wstall[i] are never 1 when m_ren[i] / m_wen[i] = 0.
//  - When a channel is idle: its s_ addr/data/bytemask outputs = 0 and its enable = 0.
//  - Stalled masters hold their request and payload stable until accepted; a request is 1 cycle when unstalled.
//  - Read return: a READ_LAT-deep shift register of {valid, id} is loaded on each accepted read.
//    Its output drives m_rvalid = valid ? (1<<id) : 0; m_rdata = s_rdata unconditionally.
//    Back-to-back reads are accepted every cycle, so up to READ_LAT reads are in flight.
//  - The read and write channels may both grant in the same cycle, to the same or different masters.
// CONFIGURATION
//  BUS_ARB_RAW_ORDER_EN defined:
//   - Suppress the read grant (s_ren = 0, stall all read requesters, rd_ptr holds) when a write is granted the same cycle
//     and the read and write target the same word (addr[31:2] equal).
//   - The read is then granted the next cycle, so it always observes the write.
//  BUS_ARB_RAW_ORDER_EN undefined:
//   - Channels are fully independent; read/write ordering on a same-word collision is defined by the slave.
// TESTING
//  1. NUM_M=2, m_ren=2'b11 every cycle for 4 cycles -> grants 0,1,0,1; m_rstall = 10,01,10,01.
//  2. Master 1 reads 0x100 at t, READ_LAT=1, slave returns 0xDEADBEEF -> at t+1 m_rvalid=2'b10, m_rdata=0xDEADBEEF.
//  3. m0 write to 0x40 (bytemask 4'b0011) and m1 read 0x80, same cycle -> s_wen=s_ren=1, no stalls.
//  4. m0 write 0x40 and m1 read 0x40, same cycle, RAW_ORDER_EN -> t: s_ren=0, m_rstall[1]=1; t+1: s_ren=1, s_raddr=0x40.
//     Same stimulus without the macro -> both granted at t.
//  5. READ_LAT=3, three back-to-back reads, then rst_n low for 1 cycle at t+1 -> m_rvalid=0 thereafter; both ptrs back to 0.
//  6. No requests for 10 cycles -> s_ren=s_wen=0, all stalls 0, ptrs unchanged.

Source files
------------

// File: rtl/bus_arbiter_if.sv
// rtl/bus_arbiter_if.sv - master-side and slave-side bus signals around bus_arbiter
// slave modport: the arbiter as seen by the masters; master modport: the arbiter driving the one slave.
interface bus_arbiter_if #(
  parameter int NUM_M = 2
);
  logic [NUM_M-1:0]    m_ren;
  logic [NUM_M*32-1:0] m_raddr;
  logic [NUM_M-1:0]    m_rstall;
  logic [31:0]         m_rdata;
  logic [NUM_M-1:0]    m_rvalid;
  logic [NUM_M-1:0]    m_wen;
  logic [NUM_M*32-1:0] m_waddr;
  logic [NUM_M*32-1:0] m_wdata;
  logic [NUM_M*4-1:0]  m_bytemask;
  logic [NUM_M-1:0]    m_wstall;

  logic                s_ren;
  logic [31:0]         s_raddr;
  logic [31:0]         s_rdata;
  logic                s_wen;
  logic [31:0]         s_waddr;
  logic [31:0]         s_wdata;
  logic [3:0]          s_bytemask;

  modport slave (
    input  m_ren, m_raddr, m_wen, m_waddr, m_wdata, m_bytemask,
    output m_rstall, m_rdata, m_rvalid, m_wstall
  );

  modport master (
    output s_ren, s_raddr, s_wen, s_waddr, s_wdata, s_bytemask,
    input  s_rdata
  );
endinterface

// File: rtl/bus_arbiter.sv
// rtl/bus_arbiter.sv - round-robin sharing of one slave between NUM_M masters, separate read/write channels
// Optional: define BUS_ARB_RAW_ORDER_EN to hold a read behind a same-word write granted in the same cycle.
module bus_arbiter #(
  parameter int NUM_M    = 2,
  parameter int READ_LAT = 1
) (
  input  logic          clk,
  input  logic          rst_n,
  bus_arbiter_if.slave  m_bus,
  bus_arbiter_if.master s_bus
);
  localparam int IW = (NUM_M > 1) ? $clog2(NUM_M) : 1;

  logic [IW-1:0]       rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [IW-1:0]       rd_gnt, wr_gnt;
  logic                rd_any, wr_any, raw_block, rd_acc;
  logic [READ_LAT-1:0] tag_vld_q, tag_vld_d;
  logic [IW-1:0]       tag_id_q [READ_LAT];
  logic [IW-1:0]       tag_id_d [READ_LAT];

  // Scan downwards so the last hit, i.e. the closest one at or after ptr, wins.
  function automatic logic [IW:0] pick(input logic [NUM_M-1:0] req, input logic [IW-1:0] ptr);
    logic [IW:0] r;
    int          idx;
    r = '0;
    for (int k = NUM_M - 1; k >= 0; k--) begin
      idx = int'(ptr) + k;
      if (idx >= NUM_M) idx = idx - NUM_M;
      if (req[idx]) r = {1'b1, IW'(idx)};
    end
    return r;
  endfunction

  always_comb begin
    {rd_any, rd_gnt} = pick(m_bus.m_ren, rd_ptr_q);
    {wr_any, wr_gnt} = pick(m_bus.m_wen, wr_ptr_q);
  end

`ifdef BUS_ARB_RAW_ORDER_EN
  assign raw_block = rd_any && wr_any &&
                     (m_bus.m_raddr[int'(rd_gnt)*32+2 +: 30] == m_bus.m_waddr[int'(wr_gnt)*32+2 +: 30]);
`else
  assign raw_block = 1'b0;
`endif

  assign rd_acc = rd_any && !raw_block;

  always_comb begin
    s_bus.s_ren     = rd_acc;
    s_bus.s_raddr   = '0;
    m_bus.m_rstall  = m_bus.m_ren;
    if (rd_acc) begin
      s_bus.s_raddr          = m_bus.m_raddr[int'(rd_gnt)*32 +: 32];
      m_bus.m_rstall[rd_gnt] = 1'b0;
    end
  end

  always_comb begin
    s_bus.s_wen      = wr_any;
    s_bus.s_waddr    = '0;
    s_bus.s_wdata    = '0;
    s_bus.s_bytemask = '0;
    m_bus.m_wstall   = m_bus.m_wen;
    if (wr_any) begin
      s_bus.s_waddr          = m_bus.m_waddr[int'(wr_gnt)*32 +: 32];
      s_bus.s_wdata          = m_bus.m_wdata[int'(wr_gnt)*32 +: 32];
      s_bus.s_bytemask       = m_bus.m_bytemask[int'(wr_gnt)*4 +: 4];
      m_bus.m_wstall[wr_gnt] = 1'b0;
    end
  end

  always_comb begin
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    if (rd_acc) rd_ptr_d = (int'(rd_gnt) == NUM_M - 1) ? '0 : rd_gnt + 1'b1;
    if (wr_any) wr_ptr_d = (int'(wr_gnt) == NUM_M - 1) ? '0 : wr_gnt + 1'b1;
  end

  // Tag pipeline mirrors the slave latency so each return is routed to its issuer.
  always_comb begin
    tag_vld_d    = '0;
    tag_vld_d[0] = rd_acc;
    tag_id_d[0]  = rd_gnt;
    for (int k = 1; k < READ_LAT; k++) begin
      tag_vld_d[k] = tag_vld_q[k-1];
      tag_id_d[k]  = tag_id_q[k-1];
    end
  end

  always_comb begin
    m_bus.m_rvalid = '0;
    if (tag_vld_q[READ_LAT-1]) m_bus.m_rvalid[tag_id_q[READ_LAT-1]] = 1'b1;
    m_bus.m_rdata = s_bus.s_rdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_ptr_q  <= '0;
      wr_ptr_q  <= '0;
      tag_vld_q <= '0;
      for (int k = 0; k < READ_LAT; k++) tag_id_q[k] <= '0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      tag_vld_q <= tag_vld_d;
      for (int k = 0; k < READ_LAT; k++) tag_id_q[k] <= tag_id_d[k];
    end
  end
endmodule

// File: tb/tb_bus_arbiter.sv
// tb/tb_bus_arbiter.sv - randomized scoreboard bench for bus_arbiter against a round-robin reference model
module tb_bus_arbiter;
  localparam int NUM_M    = 3;
  localparam int READ_LAT = 2;

  typedef struct {
    int          id;
    logic [31:0] data;
    int          due;
  } rd_exp_t;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  mask;
  } wr_exp_t;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  bus_arbiter_if #(.NUM_M(NUM_M)) bus ();

  bus_arbiter #(.NUM_M(NUM_M), .READ_LAT(READ_LAT)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .m_bus (bus),
    .s_bus (bus)
  );

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  rd_exp_t rq[$];
  wr_exp_t wq[$];

  int               rd_ptr, wr_ptr;
  logic [NUM_M-1:0] rd_pend, wr_pend;
  logic [31:0]      ra [NUM_M];
  logic [31:0]      wa [NUM_M];
  logic [31:0]      wd [NUM_M];
  logic [3:0]       wm [NUM_M];
  bit               sv [READ_LAT];
  logic [31:0]      sa [READ_LAT];

  function automatic logic [31:0] mem_f(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hA5A5_0000;
  endfunction

  function automatic int arb(input logic [NUM_M-1:0] req, input int ptr);
    for (int k = 0; k < NUM_M; k++)
      if (req[(ptr + k) % NUM_M]) return (ptr + k) % NUM_M;
    return -1;
  endfunction

  function automatic logic [31:0] rand_addr();
    return 32'h1000 + 32'($urandom_range(0, 15));
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive();
    bus.m_ren = rd_pend;
    bus.m_wen = wr_pend;
    for (int i = 0; i < NUM_M; i++) begin
      bus.m_raddr[32*i +: 32]   = ra[i];
      bus.m_waddr[32*i +: 32]   = wa[i];
      bus.m_wdata[32*i +: 32]   = wd[i];
      bus.m_bytemask[4*i +: 4]  = wm[i];
    end
  endtask

  task automatic step(input int rd_pct, input int wr_pct);
    int               rg, wg;
    logic [NUM_M-1:0] exp_rs, exp_ws;
    logic [31:0]      exp_ra;
    @(posedge clk);
    #1;
    cyc++;
    bus.s_rdata = sv[READ_LAT-1] ? mem_f(sa[READ_LAT-1]) : 32'h0;
    for (int i = 0; i < NUM_M; i++) begin
      if (!rd_pend[i] && int'($urandom_range(0, 99)) < rd_pct) begin
        rd_pend[i] = 1'b1;
        ra[i]      = rand_addr();
      end
      if (!wr_pend[i] && int'($urandom_range(0, 99)) < wr_pct) begin
        wr_pend[i] = 1'b1;
        wa[i]      = rand_addr();
        wd[i]      = $urandom;
        wm[i]      = 4'($urandom_range(0, 15));
      end
    end
    drive();
    @(negedge clk);
    rg = arb(rd_pend, rd_ptr);
    wg = arb(wr_pend, wr_ptr);
`ifdef BUS_ARB_RAW_ORDER_EN
    if (rg >= 0 && wg >= 0 && ra[rg][31:2] == wa[wg][31:2]) rg = -1;
`endif
    exp_rs = rd_pend;
    exp_ws = wr_pend;
    exp_ra = 32'h0;
    if (rg >= 0) begin
      exp_rs[rg] = 1'b0;
      exp_ra     = ra[rg];
    end
    if (wg >= 0) exp_ws[wg] = 1'b0;
    chk("s_ren", 64'(bus.s_ren), 64'(rg >= 0));
    chk("s_raddr", 64'(bus.s_raddr), 64'(exp_ra));
    chk("m_rstall", 64'(bus.m_rstall), 64'(exp_rs));
    chk("m_wstall", 64'(bus.m_wstall), 64'(exp_ws));
    if (rg >= 0) begin
      rq.push_back('{rg, mem_f(ra[rg]), cyc + READ_LAT});
      rd_pend[rg] = 1'b0;
      rd_ptr      = (rg + 1) % NUM_M;
    end
    if (wg >= 0) begin
      wq.push_back('{wa[wg], wd[wg], wm[wg]});
      wr_pend[wg] = 1'b0;
      wr_ptr      = (wg + 1) % NUM_M;
    end
    for (int k = READ_LAT - 1; k > 0; k--) begin
      sv[k] = sv[k-1];
      sa[k] = sa[k-1];
    end
    sv[0] = bus.s_ren;
    sa[0] = bus.s_raddr;
  endtask

  task automatic do_reset();
    @(posedge clk);
    #1;
    cyc++;
    rst_n   = 1'b0;
    rd_pend = '0;
    wr_pend = '0;
    drive();
    rq.delete();
    for (int k = 0; k < READ_LAT; k++) sv[k] = 1'b0;
    bus.s_rdata = 32'h0;
    rd_ptr = 0;
    wr_ptr = 0;
    @(negedge clk);
    chk("reset_s_ren", 64'(bus.s_ren), 64'(0));
    chk("reset_s_wen", 64'(bus.s_wen), 64'(0));
    chk("reset_stalls", 64'({bus.m_rstall, bus.m_wstall}), 64'(0));
    #2;
    rst_n = 1'b1;
  endtask

  initial begin : monitor
    rd_exp_t re;
    wr_exp_t we;
    forever begin
      @(negedge clk);
      #1;
      if (bus.m_rvalid !== '0) begin
        if (rq.size() == 0) begin
          chk("rvalid_unexpected", 64'(bus.m_rvalid), 64'(0));
        end else begin
          re = rq.pop_front();
          chk("rvalid_id", 64'(bus.m_rvalid), 64'(NUM_M'(1) << re.id));
          chk("rdata", 64'(bus.m_rdata), 64'(re.data));
          chk("rvalid_cycle", 64'(cyc), 64'(re.due));
        end
      end else if (rq.size() != 0 && rq[0].due <= cyc) begin
        re = rq.pop_front();
        chk("rvalid_missing", 64'(bus.m_rvalid), 64'(NUM_M'(1) << re.id));
      end
      if (bus.s_wen === 1'b1) begin
        if (wq.size() == 0) begin
          chk("s_wen_unexpected", 64'(bus.s_wen), 64'(0));
        end else begin
          we = wq.pop_front();
          chk("s_waddr", 64'(bus.s_waddr), 64'(we.addr));
          chk("s_wdata", 64'(bus.s_wdata), 64'(we.data));
          chk("s_bytemask", 64'(bus.s_bytemask), 64'(we.mask));
        end
      end else begin
        if (wq.size() != 0) begin
          void'(wq.pop_front());
          chk("s_wen_missing", 64'(bus.s_wen), 64'(1));
        end
        chk("s_waddr_idle", 64'(bus.s_waddr), 64'(0));
        chk("s_wdata_idle", 64'({bus.s_wdata, bus.s_bytemask}), 64'(0));
      end
    end
  end

  initial begin
    rst_n       = 1'b0;
    rd_pend     = '0;
    wr_pend     = '0;
    rd_ptr      = 0;
    wr_ptr      = 0;
    bus.s_rdata = 32'h0;
    for (int i = 0; i < NUM_M; i++) begin
      ra[i] = 32'h0;
      wa[i] = 32'h0;
      wd[i] = 32'h0;
      wm[i] = 4'h0;
    end
    for (int k = 0; k < READ_LAT; k++) begin
      sv[k] = 1'b0;
      sa[k] = 32'h0;
    end
    drive();
    do_reset();
    repeat (3) step(0, 0);
    repeat (4 * NUM_M) step(100, 0);
    repeat (4 * NUM_M) step(0, 100);
    repeat (6) step(100, 100);
    repeat (10) step(0, 0);
    repeat (3) step(100, 0);
    do_reset();
    repeat (2 * NUM_M) step(100, 100);
    for (int n = 0; n < 3000; n++) begin
      if (n == 1500) do_reset();
      else step(45, 45);
    end
    repeat (READ_LAT + 3) step(0, 0);
    chk("rq_drained", 64'(rq.size()), 64'(0));
    chk("wq_drained", 64'(wq.size()), 64'(0));
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
